// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF fetch and MEM load/store
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LAST   = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          streak_q, streak_d;
    logic                sel_mem_q, sel_mem_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_mem;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        sel_mem_d   = sel_mem_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        grant_mem   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // MEM wins unless IF has already waited through MAX_STREAK MEM grants
                    grant_mem   = d_req && (!if_req || (streak_q < STREAK_MAX));
                    sel_mem_d   = grant_mem;
                    streak_d    = (grant_mem && if_req) ? (streak_q + 4'd1) : 4'd0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_mem && d_we;
                    mem_addr_d  = grant_mem ? d_addr : if_addr;
                    mem_wdata_d = grant_mem ? d_wdata : '0;
                    cnt_d       = LAT_LAST;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (sel_mem_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            streak_q    <= 4'd0;
            sel_mem_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            sel_mem_q   <= sel_mem_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int MS  = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .MAX_STREAK(MS)) dut (
        .clock(clock), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          gcyc;
        int          acyc;
        bit          is_d;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] phys[logic [31:0]];
    logic [31:0] shadow[logic [31:0]];
    logic [31:0] mdl_drdata;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rem = 0;
    int          streak = 0;
    int          en_run = 0;
    bit          hot = 1'b0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h4) return 32'h2002_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys.exists(a)) return phys[a];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each access occupies LATENCY+2 cycles from the IDLE decision cycle
    always @(posedge clock) begin
        ev_t ev;
        int  t;
        bit  give_d;
        t = cyc;
        cyc = cyc + 1;
        if (!resetn) begin
            rem = 0;
            streak = 0;
            mdl_drdata = 32'h0;
            exp_q.delete();
        end else if (rem > 0) begin
            rem = rem - 1;
        end else if (if_req || d_req) begin
            give_d = d_req && (!if_req || streak < MS);
            streak = (give_d && if_req) ? streak + 1 : 0;
            ev.gcyc = t;
            ev.acyc = t + LAT + 1;
            ev.is_d = give_d;
            if (give_d) begin
                ev.addr = d_addr;
                ev.we = d_we;
                ev.wdata = d_wdata;
                if (d_we) begin
                    shadow[d_addr] = d_wdata;
                end else begin
                    mdl_drdata = shadow.exists(d_addr) ? shadow[d_addr] : init_val(d_addr);
                end
                ev.data = mdl_drdata;
            end else begin
                ev.addr = if_addr;
                ev.we = 1'b0;
                ev.wdata = 32'h0;
                ev.data = init_val(if_addr);
            end
            exp_q.push_back(ev);
            rem = LAT + 1;
        end
    end

    // Memory model (data only in the last access cycle) plus output monitor
    always @(negedge clock) begin
        ev_t ev;
        bit  exp_busy, exp_en;
        if (mem_en) en_run++; else en_run = 0;
        if (mem_en && mem_we) phys[mem_addr] = mem_wdata;
        mem_rdata = (mem_en && !mem_we && en_run == LAT) ? phys_rd(mem_addr) : $urandom();
        if (resetn) begin
            chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_ack});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, d_req & ~d_ack});
            exp_busy = 1'b0;
            exp_en = 1'b0;
            if (exp_q.size() > 0) begin
                exp_busy = (cyc > exp_q[0].gcyc) && (cyc <= exp_q[0].acyc);
                exp_en = (cyc > exp_q[0].gcyc) && (cyc < exp_q[0].acyc);
            end
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
            if (mem_en && en_run == 1 && exp_q.size() > 0) begin
                chk("mem_addr", mem_addr, exp_q[0].addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
                if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
            end
            if (if_ack && d_ack) begin
                chk("dual_ack", 32'h1, 32'h0);
            end else if (if_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", {30'd0, if_ack, d_ack}, 32'h0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("ack_winner", {31'd0, d_ack}, {31'd0, ev.is_d});
                    chk("ack_cycle", 32'(cyc), 32'(ev.acyc));
                    if (ev.is_d) chk("d_rdata", d_rdata, ev.data);
                    else chk("if_rdata", if_rdata, ev.data);
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].acyc) begin
                ev = exp_q.pop_front();
                chk("missing_ack", 32'h0, 32'h1);
            end
        end
    end

    task automatic do_if(input logic [31:0] a);
        int n = 0;
        if_req = 1'b1;
        if_addr = a;
        while (if_ack !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) chk("if_ack_timeout", 32'(n), 32'h0);
        if_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        while (d_ack !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) chk("d_ack_timeout", 32'(n), 32'h0);
        d_req = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run_if(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hot ? 0 : $urandom_range(0, 3)) begin @(posedge clock); #1; end
            do_if(32'h2000 + 32'($urandom_range(0, 255)) * 4);
        end
    endtask

    task automatic run_d(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hot ? 0 : $urandom_range(0, 3)) begin @(posedge clock); #1; end
            do_d(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15)) * 4, $urandom());
        end
    endtask

    initial begin
        resetn = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
        chk("rst_if_ack", {31'd0, if_ack}, 32'h0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        resetn = 1'b1;

        // Simultaneous first requests, then directed store/readback, then random traffic
        fork
            begin do_if(32'h4); hot = 1'b1; run_if(12); hot = 1'b0; run_if(30); end
            begin do_d(1'b1, 32'h80, 32'hDEAD_BEEF); do_d(1'b0, 32'h80, 32'h0); run_d(12); run_d(30); end
        join
        repeat (10) begin @(posedge clock); #1; end
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1004;
        @(posedge clock); #1;
        chk("busy_before_abort", {31'd0, busy}, 32'h1);
        resetn = 1'b0;
        d_req = 1'b0;
        @(posedge clock); #1;
        chk("abort_mem_en", {31'd0, mem_en}, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_d_ack", {31'd0, d_ack}, 32'h0);
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("abort_no_late_ack", {31'd0, d_ack | if_ack}, 32'h0);

        hot = 1'b1;
        fork
            run_if(6);
            run_d(10);
        join
        hot = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        chk("final_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the pipeline IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU.
- Selects one requester per transaction and sequences the memory over a fixed latency.
- Returns read data with a one-cycle ack pulse and drives stall outputs to the pipeline control.
- MEM stage has priority; a streak limit stops IF from being starved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, number of cycles the memory needs per access. Legal range 1..15.
- MAX_STREAK, 4, maximum consecutive MEM-stage grants while IF is waiting. Legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1, then held.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load result; valid when d_ack=1, then held.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last BUSY cycle.
- stall_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  d_req & ~d_ack.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset values (resetn=0 at a clock edge):
  - State = IDLE.
  - mem_en, mem_we, if_ack, d_ack, busy all 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata all 0.
  - Latency counter and streak counter both 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, latch the winner's addr, wdata and we into mem_* registers, load the counter with LATENCY-1, go to BUSY.
- Grant rules (evaluated in IDLE only):
  - d_req only: grant MEM.
  - if_req only: grant IF.
  - Both high and streak < MAX_STREAK: grant MEM and increment streak.
  - Both high and streak == MAX_STREAK: grant IF.
  - Streak clears to 0 on any IF grant, and on any MEM grant made while if_req=0.
- BUSY:
  - mem_en=1 throughout; mem_we = latched we; mem_addr and mem_wdata held stable.
  - Counter decrements each cycle.
  - In the cycle where counter==0, capture mem_rdata into the winner's rdata register (loads and fetches only; a store leaves d_rdata unchanged) and go to RESP.
- RESP:
  - mem_en=0, mem_we=0.
  - Winner's ack=1 for exactly this one cycle.
  - Return to IDLE unconditionally. No new grant is made in RESP, so a requester that drops req after ack is never double-served.
- Latency: request first seen in IDLE at cycle t → BUSY for cycles t+1..t+LATENCY → ack high in cycle t+LATENCY+1. Back-to-back throughput is one access per LATENCY+2 cycles.
- Request timing: a requester may raise a new req in the IDLE cycle right after RESP.
- A requester that drops req before its ack has no effect on the in-flight access. The ack still pulses.
- Never both acks in the same cycle; never both requesters granted.
- Stall outputs are combinational from the request inputs and the registered acks.
- Reset mid-operation: the in-flight access is abandoned with no ack and no retry. A store already presented to memory may have committed.
- Counter wrap: impossible within the legal parameter ranges. LATENCY=1 gives a single BUSY cycle.

Test Plan:
- Reset then IF-only: if_req=1, if_addr=0x4, mem returns 0x2002_0001, LATENCY=2 → mem_en high 2 cycles, if_ack pulses in the 3rd cycle after req, if_rdata=0x2002_0001, stall_if low from the ack cycle.
- Store: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEAD_BEEF → mem_we=1 with addr 0x80 / data 0xDEAD_BEEF for 2 cycles, d_ack pulses once, d_rdata keeps its previous value.
- Contention, MAX_STREAK=4: hold d_req and if_req continuously → grant order MEM, MEM, MEM, MEM, IF, MEM, …; no ack pulse is ever longer than 1 cycle.
- Simultaneous first request after reset: both req high in the same cycle → MEM wins; IF ack comes LATENCY+2 cycles after d_ack.
- Reset mid-BUSY: resetn=0 in the 1st BUSY cycle → the next cycle shows mem_en=0, no ack, state IDLE, streak=0.
- LATENCY=1 build, single load of 0x1234 → ack 2 cycles after req, d_rdata=0x1234.
